// File: rtl/cpu_pkg.sv
// Shared definitions for the dCPU RV32I pipeline: opcodes, immediate formats,
// and the enable/disable literals used by pipeline registers.
package cpu_pkg;

  localparam int XLEN = 32;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [2:0] {
    IMM_R,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_fmt_e;

  function automatic logic is_known_opcode(input logic [6:0] op);
    return (op == OPC_LUI)    || (op == OPC_AUIPC) || (op == OPC_JAL)   ||
           (op == OPC_JALR)   || (op == OPC_BRANCH) || (op == OPC_LOAD) ||
           (op == OPC_STORE)  || (op == OPC_OP_IMM) || (op == OPC_OP);
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Immediate extraction for RV32I: classifies the opcode into a format and
// builds the sign-extended immediate. Unknown opcodes yield format R and 0.
module imm_gen
  import cpu_pkg::*;
(
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output imm_fmt_e        fmt
);

  always_comb begin
    fmt = IMM_R;
    unique case (instr[6:0])
      OPC_LOAD, OPC_OP_IMM, OPC_JALR: fmt = IMM_I;
      OPC_STORE:                      fmt = IMM_S;
      OPC_BRANCH:                     fmt = IMM_B;
      OPC_LUI, OPC_AUIPC:             fmt = IMM_U;
      OPC_JAL:                        fmt = IMM_J;
      default:                        fmt = IMM_R;
    endcase
  end

  always_comb begin
    imm = '0;
    unique case (fmt)
      IMM_I: imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S: imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B: imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U: imm = {instr[31:12], 12'b0};
      IMM_J: imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/id_stage.sv
// Decode/operand-fetch stage: register-file addressing, EX/MEM/WB bypass,
// load-use stall and the ID/EX pipeline register behind a valid/ready handshake.
module id_stage
  import cpu_pkg::*;
(
  input  logic            clk,
  input  logic            rst,

  input  logic            if_valid,
  output logic            if_ready,
  input  logic [31:0]     if_pc,
  input  logic [31:0]     if_instr,

  output logic [4:0]      rs_addr1,
  output logic [4:0]      rs_addr2,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,

  input  logic            ex_wren,
  input  logic            ex_is_load,
  input  logic [4:0]      ex_rd,
  input  logic [XLEN-1:0] ex_data,
  input  logic            mem_wren,
  input  logic [4:0]      mem_rd,
  input  logic [XLEN-1:0] mem_data,
  input  logic            wb_wren,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,

  input  logic            flush,
  input  logic            ex_ready,

  output logic            id_valid,
  output logic [31:0]     id_pc,
  output logic [XLEN-1:0] id_rs1_val,
  output logic [XLEN-1:0] id_rs2_val,
  output logic [XLEN-1:0] id_imm,
  output logic [4:0]      id_rd,
  output logic [6:0]      id_opcode,
  output logic [2:0]      id_funct3,
  output logic [6:0]      id_funct7,
  output logic            id_reg_we,
  output logic            id_illegal
);

  logic [6:0]      opcode;
  logic [4:0]      rd;
  logic [XLEN-1:0] imm;
  imm_fmt_e        fmt;
  logic            known;
  logic            writes_rd;
  logic            use_rs1;
  logic            use_rs2;
  logic            load_use;
  logic            advance;
  logic [XLEN-1:0] rs1_fwd;
  logic [XLEN-1:0] rs2_fwd;

  imm_gen u_imm_gen (
    .instr (if_instr),
    .imm   (imm),
    .fmt   (fmt)
  );

  assign opcode   = if_instr[6:0];
  assign rd       = if_instr[11:7];
  assign rs_addr1 = if_instr[19:15];
  assign rs_addr2 = if_instr[24:20];
  assign known    = is_known_opcode(opcode);

  assign writes_rd = (opcode == OPC_LUI)  || (opcode == OPC_AUIPC)  ||
                     (opcode == OPC_JAL)  || (opcode == OPC_JALR)   ||
                     (opcode == OPC_LOAD) || (opcode == OPC_OP_IMM) ||
                     (opcode == OPC_OP);

  // U and J formats (LUI, AUIPC, JAL) are the only ones without rs1.
  assign use_rs1 = (fmt != IMM_U) && (fmt != IMM_J);
  assign use_rs2 = (fmt == IMM_S) || (fmt == IMM_B) || (opcode == OPC_OP);

  // A load in EX has no data yet, so it is never a bypass source.
  function automatic logic [XLEN-1:0] bypass(input logic [4:0] addr,
                                             input logic [XLEN-1:0] rf_val);
    if (addr == 5'd0)
      return '0;
    else if (ex_wren && !ex_is_load && ex_rd == addr)
      return ex_data;
    else if (mem_wren && mem_rd == addr)
      return mem_data;
    else if (wb_wren && wb_rd == addr)
      return wb_data;
    else
      return rf_val;
  endfunction

  assign rs1_fwd = bypass(rs_addr1, rs1);
  assign rs2_fwd = bypass(rs_addr2, rs2);

  assign load_use = if_valid && ex_wren && ex_is_load && (ex_rd != 5'd0) &&
                    ((use_rs1 && ex_rd == rs_addr1) || (use_rs2 && ex_rd == rs_addr2));

  assign advance  = !id_valid || ex_ready;
  assign if_ready = advance && !load_use;

  always_ff @(posedge clk) begin
    if (rst) begin
      id_valid   <= DISABLE;
      id_pc      <= '0;
      id_rs1_val <= '0;
      id_rs2_val <= '0;
      id_imm     <= '0;
      id_rd      <= '0;
      id_opcode  <= '0;
      id_funct3  <= '0;
      id_funct7  <= '0;
      id_reg_we  <= DISABLE;
      id_illegal <= DISABLE;
    end else if (flush) begin
      id_valid <= DISABLE;
    end else if (advance) begin
      id_valid   <= if_valid && !load_use;
      id_pc      <= if_pc;
      id_rs1_val <= rs1_fwd;
      id_rs2_val <= rs2_fwd;
      id_imm     <= imm;
      id_rd      <= rd;
      id_opcode  <= opcode;
      id_funct3  <= if_instr[14:12];
      id_funct7  <= if_instr[31:25];
      id_reg_we  <= known && writes_rd && (rd != 5'd0);
      id_illegal <= !known;
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: expected ID/EX contents are queued when
// each decode cycle is driven and compared after the capturing edge.
module tb_id_stage;
  import cpu_pkg::*;

  logic            clk = 1'b0;
  logic            rst;
  logic            if_valid;
  logic            if_ready;
  logic [31:0]     if_pc;
  logic [31:0]     if_instr;
  logic [4:0]      rs_addr1;
  logic [4:0]      rs_addr2;
  logic [XLEN-1:0] rf1;
  logic [XLEN-1:0] rf2;
  logic            ex_wren;
  logic            ex_is_load;
  logic [4:0]      ex_rd;
  logic [XLEN-1:0] ex_data;
  logic            mem_wren;
  logic [4:0]      mem_rd;
  logic [XLEN-1:0] mem_data;
  logic            wb_wren;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            flush;
  logic            ex_ready;
  logic            id_valid;
  logic [31:0]     id_pc;
  logic [XLEN-1:0] id_rs1_val;
  logic [XLEN-1:0] id_rs2_val;
  logic [XLEN-1:0] id_imm;
  logic [4:0]      id_rd;
  logic [6:0]      id_opcode;
  logic [2:0]      id_funct3;
  logic [6:0]      id_funct7;
  logic            id_reg_we;
  logic            id_illegal;

  typedef struct {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic        we;
    logic        ill;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  id_stage dut (
    .clk        (clk),
    .rst        (rst),
    .if_valid   (if_valid),
    .if_ready   (if_ready),
    .if_pc      (if_pc),
    .if_instr   (if_instr),
    .rs_addr1   (rs_addr1),
    .rs_addr2   (rs_addr2),
    .rs1        (rf1),
    .rs2        (rf2),
    .ex_wren    (ex_wren),
    .ex_is_load (ex_is_load),
    .ex_rd      (ex_rd),
    .ex_data    (ex_data),
    .mem_wren   (mem_wren),
    .mem_rd     (mem_rd),
    .mem_data   (mem_data),
    .wb_wren    (wb_wren),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .flush      (flush),
    .ex_ready   (ex_ready),
    .id_valid   (id_valid),
    .id_pc      (id_pc),
    .id_rs1_val (id_rs1_val),
    .id_rs2_val (id_rs2_val),
    .id_imm     (id_imm),
    .id_rd      (id_rd),
    .id_opcode  (id_opcode),
    .id_funct3  (id_funct3),
    .id_funct7  (id_funct7),
    .id_reg_we  (id_reg_we),
    .id_illegal (id_illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic expect_id(input logic v, input logic [31:0] pc, input logic [31:0] r1,
                           input logic [31:0] r2, input logic [31:0] imm,
                           input logic [4:0] rd, input logic we, input logic ill);
    exp_t e;
    e.valid = v;
    e.pc    = pc;
    e.r1    = r1;
    e.r2    = r2;
    e.imm   = imm;
    e.rd    = rd;
    e.we    = we;
    e.ill   = ill;
    sb.push_back(e);
  endtask

  task automatic tick_check();
    exp_t e;
    @(posedge clk);
    #1;
    chk("sb_depth", 32'(sb.size()), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("id_valid", 32'(id_valid), 32'(e.valid));
      if (e.valid) begin
        chk("id_pc", id_pc, e.pc);
        chk("id_rs1_val", id_rs1_val, e.r1);
        chk("id_rs2_val", id_rs2_val, e.r2);
        chk("id_imm", id_imm, e.imm);
        chk("id_reg_we", 32'(id_reg_we), 32'(e.we));
        chk("id_illegal", 32'(id_illegal), 32'(e.ill));
        if (e.we) chk("id_rd", 32'(id_rd), 32'(e.rd));
      end
    end
  endtask

  // Register-file view with no bypass active: x0 reads as zero.
  function automatic logic [31:0] rf_or_zero(input logic [4:0] a, input logic [31:0] v);
    return (a == 5'd0) ? 32'd0 : v;
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2a,
                                        input logic [4:0] rs1a, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] op);
    return {f7, rs2a, rs1a, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1a,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1a, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2a,
                                        input logic [4:0] rs1a, input logic [2:0] f3);
    return {imm[11:5], rs2a, rs1a, f3, imm[4:0], OPC_STORE};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2a,
                                        input logic [4:0] rs1a, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2a, rs1a, f3, imm[4:1], imm[11], OPC_BRANCH};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
  endfunction

  initial begin
    logic [31:0] ins;

    rst = 1'b1; if_valid = 1'b1; ex_ready = 1'b1; flush = 1'b0;
    if_pc = 32'h100; if_instr = enc_r(7'd0, 5'd2, 5'd1, 3'd0, 5'd3, OPC_OP);
    rf1 = 32'd5; rf2 = 32'd11;
    ex_wren = 1'b0; ex_is_load = 1'b0; ex_rd = '0; ex_data = '0;
    mem_wren = 1'b0; mem_rd = '0; mem_data = '0;
    wb_wren = 1'b0; wb_rd = '0; wb_data = '0;

    // Reset with a valid fetch presented
    @(posedge clk);
    #1;
    chk("rst_id_valid", 32'(id_valid), 32'd0);
    chk("rst_id_pc", id_pc, 32'd0);
    chk("rst_id_rs1_val", id_rs1_val, 32'd0);
    chk("rst_id_imm", id_imm, 32'd0);
    chk("rst_id_opcode", 32'(id_opcode), 32'd0);
    chk("rst_id_reg_we", 32'(id_reg_we), 32'd0);
    chk("rst_if_ready", 32'(if_ready), 32'd1);
    rst = 1'b0;

    // Bypass priority on x1: EX 9 > MEM 7 > WB 6 > rf 5
    ex_wren = 1'b1; ex_rd = 5'd1; ex_data = 32'd9;
    mem_wren = 1'b1; mem_rd = 5'd1; mem_data = 32'd7;
    wb_wren = 1'b1; wb_rd = 5'd1; wb_data = 32'd6;
    #1;
    chk("rs_addr1", 32'(rs_addr1), 32'd1);
    chk("rs_addr2", 32'(rs_addr2), 32'd2);
    chk("byp_if_ready", 32'(if_ready), 32'd1);
    expect_id(1'b1, 32'h100, 32'd9, 32'd11, 32'd0, 5'd3, 1'b1, 1'b0);
    tick_check();
    ex_wren = 1'b0;
    expect_id(1'b1, 32'h100, 32'd7, 32'd11, 32'd0, 5'd3, 1'b1, 1'b0);
    tick_check();
    mem_wren = 1'b0;
    expect_id(1'b1, 32'h100, 32'd6, 32'd11, 32'd0, 5'd3, 1'b1, 1'b0);
    tick_check();
    wb_rd = 5'd2; wb_data = 32'h22;
    expect_id(1'b1, 32'h100, 32'd5, 32'h22, 32'd0, 5'd3, 1'b1, 1'b0);
    tick_check();
    wb_wren = 1'b0;

    // x0 source while EX claims to write x0
    if_instr = enc_r(7'd0, 5'd2, 5'd0, 3'd0, 5'd3, OPC_OP);
    ex_wren = 1'b1; ex_rd = 5'd0; ex_data = 32'd9; rf1 = 32'hDEAD;
    expect_id(1'b1, 32'h100, 32'd0, 32'd11, 32'd0, 5'd3, 1'b1, 1'b0);
    tick_check();
    ex_wren = 1'b0;

    // addi x0 must not write
    if_instr = enc_i(12'd3, 5'd1, 3'd0, 5'd0, OPC_OP_IMM); rf1 = 32'd5;
    expect_id(1'b1, 32'h100, 32'd5, rf_or_zero(if_instr[24:20], rf2), 32'd3, 5'd0, 1'b0, 1'b0);
    tick_check();

    // Load-use: lw x5 in EX, addi x6,x5,1 in decode
    if_pc = 32'h200; if_instr = enc_i(12'd1, 5'd5, 3'd0, 5'd6, OPC_OP_IMM);
    rf1 = 32'h55;
    ex_wren = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd5; ex_data = 32'hBAD;
    #1;
    chk("lu_if_ready_stall", 32'(if_ready), 32'd0);
    expect_id(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
    tick_check();
    ex_wren = 1'b0; ex_is_load = 1'b0;
    mem_wren = 1'b1; mem_rd = 5'd5; mem_data = 32'h1234;
    #1;
    chk("lu_if_ready_resume", 32'(if_ready), 32'd1);
    expect_id(1'b1, 32'h200, 32'h1234, 32'd11, 32'd1, 5'd6, 1'b1, 1'b0);
    tick_check();
    mem_wren = 1'b0;

    // lui x6 with a load in EX whose rd matches the (unused) rs1 field
    if_pc = 32'h204; if_instr = {20'h12345, 5'd6, OPC_LUI};
    ex_wren = 1'b1; ex_is_load = 1'b1; ex_rd = if_instr[19:15];
    #1;
    chk("lui_if_ready", 32'(if_ready), 32'd1);
    expect_id(1'b1, 32'h204, rf_or_zero(if_instr[19:15], rf1),
              rf_or_zero(if_instr[24:20], rf2), 32'h12345000, 5'd6, 1'b1, 1'b0);
    tick_check();
    ex_wren = 1'b0; ex_is_load = 1'b0;

    // Immediate formats
    if_pc = 32'h300; if_instr = enc_j(21'h1FFFFC, 5'd1);
    expect_id(1'b1, 32'h300, rf_or_zero(if_instr[19:15], rf1),
              rf_or_zero(if_instr[24:20], rf2), 32'hFFFFFFFC, 5'd1, 1'b1, 1'b0);
    tick_check();
    if_pc = 32'h304; if_instr = enc_s(12'h7FF, 5'd2, 5'd1, 3'b010);
    expect_id(1'b1, 32'h304, 32'h55, 32'd11, 32'h000007FF, 5'd0, 1'b0, 1'b0);
    tick_check();
    if_pc = 32'h308; if_instr = enc_b(13'h1800, 5'd2, 5'd1, 3'b000);
    expect_id(1'b1, 32'h308, 32'h55, 32'd11, 32'hFFFFF800, 5'd0, 1'b0, 1'b0);
    tick_check();

    // Backpressure: hold for 3 cycles, then flush while stalled
    if_pc = 32'h400; if_instr = enc_i(12'd5, 5'd1, 3'd0, 5'd7, OPC_OP_IMM); rf1 = 32'h10;
    expect_id(1'b1, 32'h400, 32'h10, 32'd11, 32'd5, 5'd7, 1'b1, 1'b0);
    tick_check();
    ex_ready = 1'b0;
    if_pc = 32'h404; if_instr = enc_i(12'd9, 5'd1, 3'd0, 5'd8, OPC_OP_IMM); rf1 = 32'h99;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_if_ready", 32'(if_ready), 32'd0);
      expect_id(1'b1, 32'h400, 32'h10, 32'd11, 32'd5, 5'd7, 1'b1, 1'b0);
      tick_check();
    end
    flush = 1'b1;
    #1;
    chk("flush_if_ready", 32'(if_ready), 32'd0);
    expect_id(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
    tick_check();
    flush = 1'b0;
    #1;
    chk("post_flush_if_ready", 32'(if_ready), 32'd1);
    expect_id(1'b1, 32'h404, 32'h99, 32'd11, 32'd9, 5'd8, 1'b1, 1'b0);
    tick_check();

    // Reset while EX is stalling a valid entry
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_stall_id_valid", 32'(id_valid), 32'd0);
    chk("rst_stall_id_pc", id_pc, 32'd0);
    rst = 1'b0; if_valid = 1'b0;
    #1;
    chk("rst_stall_if_ready", 32'(if_ready), 32'd1);
    ex_ready = 1'b1; if_valid = 1'b1;

    // Illegal opcode still travels to EX
    if_pc = 32'h500; if_instr = 32'h0000007F;
    expect_id(1'b1, 32'h500, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1);
    tick_check();

    // Flush and load-use together: flush wins, fetch still held
    if_pc = 32'h600; if_instr = enc_i(12'd1, 5'd5, 3'd0, 5'd6, OPC_OP_IMM);
    ex_wren = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd5; flush = 1'b1;
    #1;
    chk("flush_lu_if_ready", 32'(if_ready), 32'd0);
    expect_id(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
    tick_check();
    flush = 1'b0; ex_wren = 1'b0; ex_is_load = 1'b0; if_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/id_stage.md
# id_stage

Decode/operand-fetch stage of the dCPU RV32I pipeline. It sits between instruction fetch and execute and drives the read ports of the register file. It resolves operand values through EX/MEM/WB bypassing and detects load-use hazards. It registers the decoded instruction into the ID/EX pipeline register behind a valid/ready handshake.

## Interface
- XLEN, 32, datapath width
- clk  in  1  pipeline clock
- rst  in  1  reset; one clock `clk`, reset `rst` is synchronous and active-high
- if_valid / if_ready  in / out  1  fetch handshake
- if_pc, if_instr  in  32  fetched PC and instruction
- rs_addr1, rs_addr2  out  5  register-file read addresses
- rs1, rs2  in  XLEN  register-file read data (combinational read)
- ex_wren, ex_is_load  in  1  EX-stage producer writes rd / is a load
- ex_rd  in  5  EX-stage destination register
- ex_data  in  XLEN  EX-stage result
- mem_wren  in  1  MEM-stage write enable
- mem_rd  in  5  MEM-stage destination register
- mem_data  in  XLEN  MEM-stage result, including load data
- wb_wren, wb_rd, wb_data  in  1/5/XLEN  same signals that drive the register-file write port
- flush  in  1  kill the ID/EX contents (branch/jump redirect)
- ex_ready  in  1  EX accepts the ID/EX register this cycle
- id_valid  out  1  ID/EX register holds an instruction
- id_pc  out  32  PC of the held instruction
- id_rs1_val, id_rs2_val, id_imm  out  XLEN  operand values and immediate
- id_rd  out  5  destination register
- id_opcode, id_funct3, id_funct7  out  7/3/7  instruction fields
- id_reg_we, id_illegal  out  1  writes rd / unknown opcode

## Operation
- rs_addr1 = if_instr[19:15] and rs_addr2 = if_instr[24:20]; both are combinational, always driven.
- Operand select, per source, in priority order:
  - address 0 → 0;
  - EX match (ex_wren, ex_rd == addr, !ex_is_load) → ex_data;
  - MEM match → mem_data;
  - WB match → wb_data;
  - otherwise the register-file value.
- Source use:
  - rs1 is used by all opcodes except LUI, AUIPC and JAL.
  - rs2 is used by BRANCH, STORE and OP.
- load_use = if_valid & ex_wren & ex_is_load & ex_rd != 0 & ex_rd matches a used source.
- Immediate generation, all sign-extended from bit 31:
  - I: LOAD, OP-IMM, JALR
  - S: STORE
  - B: BRANCH
  - U: LUI, AUIPC
  - J: JAL
  - R-type: 0
- id_reg_we = 1 for LUI, AUIPC, JAL, JALR, LOAD, OP-IMM and OP when rd != 0; otherwise 0.
- An unknown opcode sets id_illegal = 1 and id_reg_we = 0; id_valid is still raised so EX can trap.
- advance = !id_valid | ex_ready.
- if_ready = advance & !load_use.
- Register update on posedge clk:
  - rst → all id_* = 0, id_valid = 0.
  - else flush → id_valid = 0; other fields don't-care.
  - else advance → id_valid = if_valid & !load_use; all fields are loaded from the current decode.
  - else → hold every field.
- Load-use: one bubble (id_valid = 0) is inserted and the IF instruction stays presented. Next cycle the load is in MEM and its value arrives via the MEM bypass.
- Flush and load_use in the same cycle: flush wins, and if_ready follows the rule above.
- rst mid-stall: the ID/EX register clears immediately; if_ready is 1 on the first cycle after reset when if_valid = 0.

## Timing
- Decode-to-ID/EX latency is 1 cycle.
- Operand values are sampled at capture. Held entries do not re-bypass; producers ahead of them cannot retire before EX consumes them.
- if_ready is a combinational function of id_valid, ex_ready and the fetch/EX inputs. There is no path from id_* outputs back to if_ready except through id_valid.
- A WB write in the same cycle as the read is bypassed, because the register file only updates at the clock edge.

## Structure
- Shared package `cpu_pkg`:
  - opcode constants (LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP_IMM, OP);
  - immediate-format enum;
  - the `ENABLE/`DISABLE constants.
- One combinational sub-module `imm_gen` (instr → imm, fmt). Decode, bypass and the pipeline register stay in `id_stage`.

## Test plan
- Reset: assert rst with if_valid = 1 → id_valid = 0 and all id_* = 0 on the next edge; if_ready = 1 with ex_ready = 1.
- Bypass priority:
  - Setup: `add x3,x1,x2`, rf x1 = 5. EX writes x1 = 9, MEM writes x1 = 7, WB writes x1 = 6.
  - Expect id_rs1_val = 9; with EX dropped, 7; then 6; then 5.
  - x0 read with EX writing x0 → 0.
- Load-use:
  - Setup: `lw x5` in EX, then `addi x6,x5,1`.
  - Expect if_ready = 0 for 1 cycle and one bubble.
  - Next cycle mem_data = 0x1234 is captured into id_rs1_val.
  - `lui x6` in the same situation → no stall.
- Immediates:
  - `jal` with offset −4 → id_imm = 0xFFFFFFFC.
  - `sw` with offset 0x7FF → 0x000007FF.
  - `beq` with offset −2048 → 0xFFFFF800.
- Backpressure/flush:
  - ex_ready = 0 for 3 cycles → id_* held and if_ready = 0.
  - flush while stalled → id_valid = 0 next cycle.
- Illegal opcode 0x7F → id_illegal = 1, id_reg_we = 0, id_valid = 1.
